// File: rtl/prefix_addsub_pipe.sv
// Pipelined Kogge-Stone adder/subtractor with ALU flags and a sideband tag.
// Stage S0 forms bitwise generate/propagate, stages S1..S_LVL each do one prefix
// level, and a final output stage forms the sum and flags. Latency is LVL+1 cycles.
// A full-pipeline stall (out_valid && !out_ready) freezes every stage.
module prefix_addsub_pipe #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_op,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             out_zero,
  output logic             out_neg,
  output logic [TAG_W-1:0] out_tag
);

  localparam int unsigned LVL = $clog2(WIDTH);
  localparam int unsigned NST = LVL + 1;  // prefix-path stages S0..S_LVL

  // Per-stage state
  logic [WIDTH-1:0] g_q    [NST];
  logic [WIDTH-1:0] g_d    [NST];
  logic [WIDTH-1:0] p_q    [NST];
  logic [WIDTH-1:0] p_d    [NST];
  logic [WIDTH-1:0] praw_q [NST];
  logic             cin_q  [NST];
  logic [TAG_W-1:0] tag_q  [NST];
  logic             vld_q  [NST];

  // Output stage
  logic             out_valid_q;
  logic [WIDTH-1:0] out_sum_q;
  logic             out_cout_q;
  logic             out_ovf_q;
  logic             out_zero_q;
  logic             out_neg_q;
  logic [TAG_W-1:0] out_tag_q;

  logic             stall;
  logic [WIDTH-1:0] b_mod;
  int unsigned      span;
  logic [WIDTH-1:0] carry;
  logic [WIDTH-1:0] sum_c;
  logic             cout_c;
  logic             ovf_c;

  assign stall    = out_valid_q && !out_ready;
  assign in_ready = !stall;

  // Operand conditioning and one Kogge-Stone level per stage
  always_comb begin
    b_mod   = in_op ? ~in_b : in_b;
    g_d[0]  = in_a & b_mod;
    p_d[0]  = in_a ^ b_mod;
    // Carry-in acts as a generate entering below bit 0.
    g_d[0][0] = (in_a[0] & b_mod[0]) | ((in_a[0] ^ b_mod[0]) & in_cin);
    span = 0;
    for (int unsigned k = 1; k < NST; k++) begin
      span   = 32'd1 << (k - 1);
      g_d[k] = g_q[k-1];
      p_d[k] = p_q[k-1];
      for (int unsigned i = 0; i < WIDTH; i++) begin
        if (i >= span) begin
          g_d[k][i] = g_q[k-1][i] | (p_q[k-1][i] & g_q[k-1][i-span]);
          p_d[k][i] = p_q[k-1][i] & p_q[k-1][i-span];
        end
      end
    end
  end

  // Sum and flags from the fully resolved prefix generates
  always_comb begin
    carry  = {g_q[LVL][WIDTH-2:0], cin_q[LVL]};
    sum_c  = praw_q[LVL] ^ carry;
    cout_c = g_q[LVL][WIDTH-1];
    // Signed overflow: carry into the MSB differs from carry out of it.
    ovf_c  = carry[WIDTH-1] ^ cout_c;
  end

  // Pipeline registers; everything holds while the output is stalled
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned k = 0; k < NST; k++) begin
        g_q[k]    <= '0;
        p_q[k]    <= '0;
        praw_q[k] <= '0;
        cin_q[k]  <= 1'b0;
        tag_q[k]  <= '0;
        vld_q[k]  <= 1'b0;
      end
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_cout_q  <= 1'b0;
      out_ovf_q   <= 1'b0;
      out_zero_q  <= 1'b0;
      out_neg_q   <= 1'b0;
      out_tag_q   <= '0;
    end else if (!stall) begin
      vld_q[0]  <= in_valid;
      g_q[0]    <= g_d[0];
      p_q[0]    <= p_d[0];
      praw_q[0] <= p_d[0];
      cin_q[0]  <= in_cin;
      tag_q[0]  <= in_tag;
      for (int unsigned k = 1; k < NST; k++) begin
        vld_q[k]  <= vld_q[k-1];
        g_q[k]    <= g_d[k];
        p_q[k]    <= p_d[k];
        praw_q[k] <= praw_q[k-1];
        cin_q[k]  <= cin_q[k-1];
        tag_q[k]  <= tag_q[k-1];
      end
      out_valid_q <= vld_q[LVL];
      // Data only moves on a real result so fields stay zero until the first one.
      if (vld_q[LVL]) begin
        out_sum_q  <= sum_c;
        out_cout_q <= cout_c;
        out_ovf_q  <= ovf_c;
        out_zero_q <= (sum_c == '0);
        out_neg_q  <= sum_c[WIDTH-1];
        out_tag_q  <= tag_q[LVL];
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_cout  = out_cout_q;
  assign out_ovf   = out_ovf_q;
  assign out_zero  = out_zero_q;
  assign out_neg   = out_neg_q;
  assign out_tag   = out_tag_q;

endmodule

// File: tb/tb_prefix_addsub_pipe.sv
// Scoreboard bench for prefix_addsub_pipe at WIDTH 8, 16 and 4.
module tb_prefix_addsub_pipe;

  typedef struct packed {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
    logic        neg;
    logic [3:0]  tag;
  } res_t;

  typedef struct {
    res_t r;
    int   acc;
    bit   lat;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        iv   [3];
  logic        ordy [3];
  logic        icin [3];
  logic        iop  [3];
  logic [15:0] ia   [3];
  logic [15:0] ib   [3];
  logic [3:0]  itag [3];
  logic        ir   [3];
  logic        ov   [3];
  res_t        obs  [3];

  logic ir8, ov8, co8, of8, z8, n8;
  logic [7:0] s8;
  logic [3:0] t8;
  logic ir16, ov16, co16, of16, z16, n16;
  logic [15:0] s16;
  logic [3:0] t16;
  logic ir4, ov4, co4, of4, z4, n4;
  logic [3:0] s4;
  logic [3:0] t4;

  prefix_addsub_pipe #(.WIDTH(8), .TAG_W(4)) u_d8 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir8),
    .in_a(ia[0][7:0]), .in_b(ib[0][7:0]), .in_cin(icin[0]), .in_op(iop[0]),
    .in_tag(itag[0]), .out_valid(ov8), .out_ready(ordy[0]), .out_sum(s8),
    .out_cout(co8), .out_ovf(of8), .out_zero(z8), .out_neg(n8), .out_tag(t8)
  );

  prefix_addsub_pipe #(.WIDTH(16), .TAG_W(4)) u_d16 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir16),
    .in_a(ia[1]), .in_b(ib[1]), .in_cin(icin[1]), .in_op(iop[1]),
    .in_tag(itag[1]), .out_valid(ov16), .out_ready(ordy[1]), .out_sum(s16),
    .out_cout(co16), .out_ovf(of16), .out_zero(z16), .out_neg(n16), .out_tag(t16)
  );

  prefix_addsub_pipe #(.WIDTH(4), .TAG_W(4)) u_d4 (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir4),
    .in_a(ia[2][3:0]), .in_b(ib[2][3:0]), .in_cin(icin[2]), .in_op(iop[2]),
    .in_tag(itag[2]), .out_valid(ov4), .out_ready(ordy[2]), .out_sum(s4),
    .out_cout(co4), .out_ovf(of4), .out_zero(z4), .out_neg(n4), .out_tag(t4)
  );

  always_comb begin
    ir[0] = ir8;  ov[0] = ov8;
    ir[1] = ir16; ov[1] = ov16;
    ir[2] = ir4;  ov[2] = ov4;
    obs[0] = '{sum: {8'h00, s8}, cout: co8, ovf: of8, zero: z8, neg: n8, tag: t8};
    obs[1] = '{sum: s16, cout: co16, ovf: of16, zero: z16, neg: n16, tag: t16};
    obs[2] = '{sum: {12'h000, s4}, cout: co4, ovf: of4, zero: z4, neg: n4, tag: t4};
  end

  int cyc = 0;
  always_ff @(posedge clk) cyc <= cyc + 1;

  int   checks = 0;
  int   passed = 0;
  bit   rdy_rand = 1'b0;
  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  task automatic chk(input string name, input bit ok, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (ok) passed++;
    else $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, req);
  endtask

  function automatic int lat_of(input int d);
    case (d)
      0:       return 4;
      1:       return 5;
      default: return 3;
    endcase
  endfunction

  function automatic int width_of(input int d);
    case (d)
      0:       return 8;
      1:       return 16;
      default: return 4;
    endcase
  endfunction

  function automatic int qsize(input int d);
    case (d)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  task automatic qpush(input int d, input exp_t e);
    case (d)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic qpop(input int d, output exp_t e);
    case (d)
      0:       e = q0.pop_front();
      1:       e = q1.pop_front();
      default: e = q2.pop_front();
    endcase
  endtask

  // Reference: plain integer arithmetic, signed range test for overflow.
  function automatic res_t model(input int w, input logic [15:0] a, input logic [15:0] b,
                                 input logic c, input logic o, input logic [3:0] tag);
    longint mask, ua, ub, full, sum, half, sa, sb, ssum;
    res_t   r;
    mask = (longint'(1) << w) - 1;
    half = longint'(1) << (w - 1);
    ua   = longint'(a) & mask;
    ub   = (o ? ~longint'(b) : longint'(b)) & mask;
    full = ua + ub + longint'(c);
    sum  = full & mask;
    sa   = (ua >= half) ? ua - (mask + 1) : ua;
    sb   = (ub >= half) ? ub - (mask + 1) : ub;
    ssum = sa + sb + longint'(c);
    r.sum  = 16'(sum);
    r.cout = ((full >> w) & 1) != 0;
    r.ovf  = (ssum >= half) || (ssum < -half);
    r.zero = (sum == 0);
    r.neg  = ((sum >> (w - 1)) & 1) != 0;
    r.tag  = tag;
    return r;
  endfunction

  // Monitor: pops the scoreboard on each consumed result, checks handshake and stall hold.
  bit   prev_stall [3];
  res_t prev_obs   [3];
  initial begin
    exp_t e;
    for (int d = 0; d < 3; d++) prev_stall[d] = 1'b0;
    forever begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        if (rst) begin
          prev_stall[d] = 1'b0;
        end else begin
          chk("in_ready", ir[d] == !(ov[d] && !ordy[d]), 32'(ir[d]),
              32'(!(ov[d] && !ordy[d])));
          if (prev_stall[d])
            chk("stall_hold", ov[d] && (obs[d] == prev_obs[d]), 32'(obs[d]),
                32'(prev_obs[d]));
          if (ov[d] && ordy[d]) begin
            if (qsize(d) == 0) begin
              chk("unexpected_output", 1'b0, 32'(obs[d]), 32'h0);
            end else begin
              qpop(d, e);
              chk("result", obs[d] == e.r, 32'(obs[d]), 32'(e.r));
              if (e.lat)
                chk("latency", (cyc - e.acc - 1) == lat_of(d), 32'(cyc - e.acc - 1),
                    32'(lat_of(d)));
            end
          end
          prev_stall[d] = ov[d] && !ordy[d];
          prev_obs[d]   = obs[d];
        end
      end
    end
  end

  function automatic logic pick_ready();
    return rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
  endfunction

  // Called just after a rising edge; returns just after the edge that accepts the op.
  task automatic send(input int d, input logic [15:0] a, input logic [15:0] b,
                      input logic c, input logic o, input logic [3:0] tag,
                      input bit use_e, input res_t e_in, input bit push_it);
    exp_t e;
    int   n;
    ia[d] = a; ib[d] = b; icin[d] = c; iop[d] = o; itag[d] = tag; iv[d] = 1'b1;
    ordy[d] = pick_ready();
    n = 0;
    @(negedge clk);
    while (!ir[d] && n < 200) begin
      @(posedge clk); #1;
      ordy[d] = pick_ready();
      @(negedge clk);
      n++;
    end
    if (!ir[d]) begin
      chk("accept_timeout", 1'b0, 32'(ir[d]), 32'h1);
    end else if (push_it) begin
      e.r   = use_e ? e_in : model(width_of(d), a, b, c, o, tag);
      e.acc = cyc;
      e.lat = !rdy_rand;
      qpush(d, e);
    end
    @(posedge clk); #1;
  endtask

  task automatic drain(input int d);
    int n;
    iv[d] = 1'b0;
    n = 0;
    while (qsize(d) != 0 && n < 1000) begin
      @(posedge clk); #1;
      ordy[d] = pick_ready();
      n++;
    end
    if (qsize(d) != 0) chk("drain_timeout", 1'b0, 32'(qsize(d)), 32'h0);
    ordy[d] = 1'b1;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic check_reset(input int d);
    chk("reset_out_valid", ov[d] == 1'b0, 32'(ov[d]), 32'h0);
    chk("reset_outputs", obs[d] == '0, 32'(obs[d]), 32'h0);
    chk("reset_in_ready", ir[d] == 1'b1, 32'(ir[d]), 32'h1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int d = 0; d < 3; d++) begin
      iv[d] = 1'b0; ordy[d] = 1'b1; icin[d] = 1'b0; iop[d] = 1'b0;
      ia[d] = '0; ib[d] = '0; itag[d] = '0;
    end
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 3; d++) check_reset(d);
    @(posedge clk); #1;

    // Directed boundary cases with hand-computed results
    send(0, 16'h00FF, 16'h0001, 1'b0, 1'b0, 4'd3, 1'b1,
         '{sum: 16'h0000, cout: 1'b1, ovf: 1'b0, zero: 1'b1, neg: 1'b0, tag: 4'd3}, 1'b1);
    drain(0);
    send(0, 16'h0080, 16'h0001, 1'b1, 1'b1, 4'd5, 1'b1,
         '{sum: 16'h007F, cout: 1'b1, ovf: 1'b1, zero: 1'b0, neg: 1'b0, tag: 4'd5}, 1'b1);
    drain(0);
    send(0, 16'h0000, 16'h0001, 1'b1, 1'b1, 4'd6, 1'b1,
         '{sum: 16'h00FF, cout: 1'b0, ovf: 1'b0, zero: 1'b0, neg: 1'b1, tag: 4'd6}, 1'b1);
    drain(0);
    send(2, 16'h000F, 16'h0000, 1'b1, 1'b0, 4'd9, 1'b1,
         '{sum: 16'h0000, cout: 1'b1, ovf: 1'b0, zero: 1'b1, neg: 1'b0, tag: 4'd9}, 1'b1);
    drain(2);

    // Back-to-back random stream, no backpressure: latency checked per op
    for (int i = 0; i < 100; i++)
      send(1, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 4'($urandom),
           1'b0, '0, 1'b1);
    drain(1);

    // Random backpressure and input gaps
    rdy_rand = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        iv[1] = 1'b0;
        ordy[1] = pick_ready();
        @(posedge clk); #1;
      end
      send(1, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 4'($urandom),
           1'b0, '0, 1'b1);
    end
    drain(1);
    rdy_rand = 1'b0;

    // Reset with three ops in flight: none may ever appear
    for (int i = 0; i < 3; i++)
      send(1, 16'($urandom), 16'($urandom), 1'b0, 1'b0, 4'(i), 1'b0, '0, 1'b0);
    iv[1] = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_reset(1);
    @(posedge clk); #1;
    repeat (10) @(posedge clk);
    #1;
    send(1, 16'h1234, 16'h4321, 1'b0, 1'b0, 4'd7, 1'b1,
         '{sum: 16'h5555, cout: 1'b0, ovf: 1'b0, zero: 1'b0, neg: 1'b0, tag: 4'd7}, 1'b1);
    drain(1);

    // Exhaustive WIDTH=4
    for (int o = 0; o < 2; o++)
      for (int c = 0; c < 2; c++)
        for (int a = 0; a < 16; a++)
          for (int b = 0; b < 16; b++)
            send(2, 16'(a), 16'(b), 1'(c), 1'(o), 4'(a ^ b), 1'b0, '0, 1'b1);
    drain(2);

    // WIDTH=8 random with backpressure
    rdy_rand = 1'b1;
    for (int i = 0; i < 60; i++)
      send(0, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 4'($urandom),
           1'b0, '0, 1'b1);
    drain(0);
    rdy_rand = 1'b0;

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
